// File: rtl/nibble_serial_adder_pkg.sv
// ============================================================================
// nibble_serial_adder_pkg : shared nibble width and sequencer state encoding
// Revision: 1.0
// ============================================================================
`default_nettype none

package nibble_serial_adder_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/nibble_adder4.sv
// ============================================================================
// nibble_adder4 : combinational 4-bit add slice with carry in/out
// Revision: 1.0
// ============================================================================
`default_nettype none

module nibble_adder4
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             cout
);

    logic [NIB_W:0] w_full;

    assign w_full = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, cin};
    assign sum    = w_full[NIB_W-1:0];
    assign cout   = w_full[NIB_W];

endmodule

`default_nettype wire

// File: rtl/nibble_serial_adder.sv
// ============================================================================
// nibble_serial_adder : WIDTH-bit add sequenced one nibble per clock through
// a single 4-bit slice. Optional carry-in port: NIBBLE_SERIAL_ADDER_CIN_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef NIBBLE_SERIAL_ADDER_CIN_EN
    input  logic             cin,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NIB    = WIDTH / NIB_W;
    localparam int STEP_W = (NIB > 1) ? $clog2(NIB) : 1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [WIDTH-1:0]    r_sum;
    logic                r_carry;
    logic                r_cout;
    logic [STEP_W-1:0]   r_step;

    logic                w_cin;
    logic                w_last;
    logic [NIB_W-1:0]    w_sl_sum;
    logic                w_sl_cout;
    logic [WIDTH-1:0]    w_sum_shift;

`ifdef NIBBLE_SERIAL_ADDER_CIN_EN
    assign w_cin = cin;
`else
    assign w_cin = 1'b0;
`endif

    assign w_last = (r_step == STEP_W'(NIB - 1));

    nibble_adder4 u_slice (
        .a    (r_a[NIB_W-1:0]),
        .b    (r_b[NIB_W-1:0]),
        .cin  (r_carry),
        .sum  (w_sl_sum),
        .cout (w_sl_cout)
    );

    // Result fills from the MSB end so the first nibble lands at the bottom after NIB shifts
    generate
        if (NIB > 1) begin : g_multi
            assign w_sum_shift = {w_sl_sum, r_sum[WIDTH-1:NIB_W]};
        end else begin : g_single
            assign w_sum_shift = w_sl_sum;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_step  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= w_cin;
                        r_step  <= '0;
                    end
                end
                S_RUN: begin
                    r_a     <= r_a >> NIB_W;
                    r_b     <= r_b >> NIB_W;
                    r_sum   <= w_sum_shift;
                    r_carry <= w_sl_cout;
                    r_step  <= r_step + STEP_W'(1);
                    if (w_last) begin
                        r_cout <= w_sl_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
// ============================================================================
// tb_nibble_serial_adder : scoreboard bench, directed plus random operands
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_nibble_serial_adder;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    typedef struct {
        logic [WIDTH:0] res;
        int             acc;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin_d;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int   cyc         = 0;
    int   vectors     = 0;
    int   miscompares = 0;
    int   bp_hold     = 0;
    bit   bp_random   = 0;
    bit   seen        = 0;
    exp_t q[$];
    exp_t cur;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef NIBBLE_SERIAL_ADDER_CIN_EN
        .cin       (cin_d),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: plain (WIDTH+1)-bit addition of the operands and carry-in
    task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v, input logic tc);
        int   waitc = 0;
        exp_t e;
        @(negedge clk);
        a        = ta;
        b        = tb_v;
        cin_d    = tc;
        in_valid = 1'b1;
        while (!in_ready && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_ready) begin
            miscompares++;
            $display("FAIL accept_timeout: in_ready stuck low for %0d cycles, expected 1", waitc);
            in_valid = 1'b0;
            return;
        end
        e.res = {1'b0, ta} + {1'b0, tb_v};
`ifdef NIBBLE_SERIAL_ADDER_CIN_EN
        e.res = e.res + (WIDTH+1)'(tc);
`endif
        e.acc = cyc + 1;
        q.push_back(e);
        vectors++;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Monitor and sink: pops expectations on each new result, checks hold-stability
    initial begin
        bit consumed = 0;
        int stall    = 0;
        int hold     = 0;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen      = 0;
                consumed  = 0;
                out_ready = 1'b0;
            end else begin
                if (consumed) begin
                    chk("post_ack_out_valid", 64'(out_valid), 0);
                    chk("post_ack_in_ready", 64'(in_ready), 1);
                    consumed = 0;
                end else if (out_valid) begin
                    if (!seen) begin
                        if (q.size() == 0) begin
                            miscompares++;
                            $display("FAIL unexpected_result: out_valid=1 sum=0x%0h with empty scoreboard", sum);
                        end else begin
                            cur   = q.pop_front();
                            seen  = 1;
                            stall = 0;
                            hold  = bp_random ? int'($urandom_range(0, 3)) : bp_hold;
                            chk("latency", 64'(cyc - cur.acc), 64'(NIB));
                            chk("sum", 64'(sum), 64'(cur.res[WIDTH-1:0]));
                            chk("cout", 64'(cout), 64'(cur.res[WIDTH]));
                            chk("in_ready_done", 64'(in_ready), 0);
                        end
                    end else begin
                        chk("hold_sum", 64'(sum), 64'(cur.res[WIDTH-1:0]));
                        chk("hold_cout", 64'(cout), 64'(cur.res[WIDTH]));
                        chk("hold_in_ready", 64'(in_ready), 0);
                    end
                end
                if (out_valid && seen) begin
                    if (stall < hold) begin
                        out_ready = 1'b0;
                        stall++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end else begin
                    out_ready = 1'b0;
                end
                if (out_valid && out_ready && seen) begin
                    consumed = 1;
                    seen     = 0;
                end
            end
        end
    end

    initial begin
        int waitc;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        cin_d    = 1'b0;
        #12;
        chk("rst_in_ready", 64'(in_ready), 1);
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_sum", 64'(sum), 0);
        chk("rst_cout", 64'(cout), 0);
        @(negedge clk);
        rst_n = 1'b1;

        send(16'h1234, 16'h0FFF, 1'b0);
        send(16'hFFFF, 16'h0001, 1'b0);

        bp_hold = 3;
        send(16'h8000, 16'h8001, 1'b0);
        repeat (8) @(negedge clk);
        bp_hold = 0;

        send(16'h5A5A, 16'h0F0F, 1'b0);
        @(negedge clk);
        a        = 16'h1111;
        b        = 16'h1111;
        in_valid = 1'b1;
        chk("ignored_in_ready_0", 64'(in_ready), 0);
        @(negedge clk);
        chk("ignored_in_ready_1", 64'(in_ready), 0);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);

        send(16'hABCD, 16'h1357, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrun_rst_out_valid", 64'(out_valid), 0);
        chk("midrun_rst_sum", 64'(sum), 0);
        chk("midrun_rst_cout", 64'(cout), 0);
        chk("midrun_rst_in_ready", 64'(in_ready), 1);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send(16'h0001, 16'h0002, 1'b0);

`ifdef NIBBLE_SERIAL_ADDER_CIN_EN
        send(16'hFFFF, 16'h0000, 1'b1);
        send(16'h0000, 16'h0000, 1'b1);
`endif

        bp_random = 1;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
        end

        waitc = 0;
        while ((q.size() != 0 || seen) && waitc < 500) begin
            @(negedge clk);
            waitc++;
        end
        chk("drain_pending", 64'(q.size()), 0);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
